// File: rtl/hh_pkg.sv
// Shared definitions for the HH/STDP neuron chip input path.
// Holds the datapath width, header constant, frame FSM encoding and FIFO entry layout.
// Imported by the stimulus receiver and its FIFO.
package hh_pkg;

  // Neuron datapath word width and its fractional bit count.
  localparam int WIDTH        = 16;
  localparam int DECIMAL_BITS = 8;

  // Upper nibble that marks a valid frame header byte.
  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  // Frame FSM state encoding.
  typedef logic [1:0] frame_state_t;
  localparam frame_state_t ST_IDLE    = 2'd0;
  localparam frame_state_t ST_WAIT_HI = 2'd1;
  localparam frame_state_t ST_WAIT_LO = 2'd2;

  // One queued stimulus: repeat count (offered hold+1 times) and current word.
  typedef struct packed {
    logic [3:0]       hold;
    logic [WIDTH-1:0] cur;
  } stim_entry_t;

endpackage

// File: rtl/stim_packet_rx_if.sv
// Valid/ready stimulus current channel from the receiver to the first neuron.
// The receiver is the master and drives data/valid; the neuron drives ready.
// A word transfers on any cycle where valid and ready are both high.
interface stim_packet_rx_if #(
  parameter int WIDTH = 16
) ();

  logic [WIDTH-1:0] cur_data;
  logic             cur_valid;
  logic             cur_ready;

  modport master (output cur_data, output cur_valid, input cur_ready);
  modport slave  (input cur_data, input cur_valid, output cur_ready);

endinterface

// File: rtl/stim_fifo.sv
// Synchronous FIFO of stimulus entries, DEPTH entries (power of two, at least 2).
// Read data is the head entry combinationally; writes land one cycle after push.
// Push while full is accepted only if a pop happens in the same cycle.
module stim_fifo
  import hh_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  stim_entry_t            push_dat,
  input  logic                   pop,
  output stim_entry_t            pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  stim_entry_t       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem[rd_ptr];
  assign level   = cnt;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/stim_packet_rx.sv
// Receives 3-byte stimulus frames from the strobed pad bus and offers them to the neuron.
// Latency: last byte event to FIFO write 1 cycle, to cur_valid 2 cycles when output is idle.
// Backpressure: holds data while cur_ready is low; frames arriving with a full FIFO are dropped (sticky overflow).
module stim_packet_rx
  import hh_pkg::*;
#(
  parameter int WIDTH   = hh_pkg::WIDTH,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             byte_in,
  input  logic                   byte_stb,
  stim_packet_rx_if.master       stim,
  output logic                   overflow,
  output logic [7:0]             err_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  // Strobe synchronizer: [0],[1] are the two sync flops, [2] is the edge-detect delay.
  logic [2:0]   stb_sync;
  logic         byte_evt;

  frame_state_t state;
  logic [3:0]   hold_r;
  logic [7:0]   hi_r;
  logic [TW-1:0] tmo_cnt;
  logic         timeout;
  logic         bad_hdr;
  logic         frame_push;
  stim_entry_t  push_dat;

  stim_entry_t  pop_dat;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;

  logic [WIDTH-1:0] cur_data_r;
  logic             cur_valid_r;
  logic [3:0]       rep_cnt;
  logic             hs;
  logic             retire;

  // Bring the asynchronous pad strobe into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stb_sync <= '0;
    end else begin
      stb_sync <= {stb_sync[1:0], byte_stb};
    end
  end

  assign byte_evt = stb_sync[1] & ~stb_sync[2];

  // Frame decode: timeout wins over a byte arriving on the same cycle.
  always_comb begin
    timeout       = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);
    bad_hdr       = (state == ST_IDLE) && byte_evt && (byte_in[7:4] != HDR_NIBBLE);
    frame_push    = (state == ST_WAIT_LO) && byte_evt && !timeout;
    push_dat      = '0;
    push_dat.hold = hold_r;
    push_dat.cur  = {hi_r, byte_in};
  end

  // Frame FSM with inter-byte timeout; a timed-out partial frame is discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hold_r  <= '0;
      hi_r    <= '0;
      tmo_cnt <= '0;
    end else if (timeout) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (byte_evt && (byte_in[7:4] == HDR_NIBBLE)) begin
            hold_r <= byte_in[3:0];
            state  <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (byte_evt) begin
            hi_r    <= byte_in;
            tmo_cnt <= '0;
            state   <= ST_WAIT_LO;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (byte_evt) begin
            tmo_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of rejected headers and inter-byte timeouts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((bad_hdr || timeout) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  // Sticky flag for a completed frame that found no room in the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (frame_push && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  stim_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (frame_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Output stage: refill whenever empty or retiring, so back-to-back entries stream without gaps.
  assign hs       = cur_valid_r && stim.cur_ready;
  assign retire   = hs && (rep_cnt == 4'd0);
  assign fifo_pop = !fifo_empty && (!cur_valid_r || retire);

  // Load, repeat and retire the offered stimulus word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_data_r  <= '0;
      cur_valid_r <= 1'b0;
      rep_cnt     <= '0;
    end else if (fifo_pop) begin
      cur_data_r  <= pop_dat.cur;
      rep_cnt     <= pop_dat.hold;
      cur_valid_r <= 1'b1;
    end else if (retire) begin
      cur_valid_r <= 1'b0;
    end else if (hs) begin
      rep_cnt <= rep_cnt - 1'b1;
    end
  end

  assign stim.cur_data  = cur_data_r;
  assign stim.cur_valid = cur_valid_r;

endmodule

// File: tb/tb_stim_packet_rx.sv
// Directed bench for stim_packet_rx: frames, backpressure, overflow, errors, reset, streaming.
// Inputs change on the falling edge; a monitor logs every handshake just after it.
// Expected values are hand-computed constants per scenario.
module tb_stim_packet_rx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_stb = 1'b0;
  logic       overflow;
  logic [7:0] err_cnt;
  logic [2:0] fifo_level;

  stim_packet_rx_if #(.WIDTH(16)) stim_bus ();

  stim_packet_rx #(
    .WIDTH   (16),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (byte_in),
    .byte_stb   (byte_stb),
    .stim       (stim_bus),
    .overflow   (overflow),
    .err_cnt    (err_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] hs_dat [$];
  int          hs_cyc [$];
  int          rise_cyc = 0;
  int          last_stb_cyc = 0;
  logic        prev_vld = 1'b0;

  // Handshake monitor, sampled just after the falling edge so driven inputs have settled.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (stim_bus.cur_valid && !prev_vld) rise_cyc = cyc;
      if (stim_bus.cur_valid && stim_bus.cur_ready) begin
        hs_dat.push_back(stim_bus.cur_data);
        hs_cyc.push_back(cyc);
      end
      prev_vld = stim_bus.cur_valid;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    tick(1);
    last_stb_cyc = cyc;
    byte_stb = 1'b1;
    tick(3);
    byte_stb = 1'b0;
    tick(3);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] cur);
    send_byte(hdr);
    send_byte(cur[15:8]);
    send_byte(cur[7:0]);
  endtask

  initial begin
    int bad;
    stim_bus.cur_ready = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    chk("rst_valid", stim_bus.cur_valid, 0);
    chk("rst_data", stim_bus.cur_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_level", fifo_level, 0);
    rst_n = 1'b1;
    tick(2);

    // Single frame, hold=2 -> three handshakes of 0x0180
    stim_bus.cur_ready = 1'b1;
    hs_dat.delete();
    send_frame(8'hA2, 16'h0180);
    tick(5);
    chk("single_cnt", hs_dat.size(), 3);
    for (int i = 0; i < hs_dat.size(); i++) chk("single_dat", hs_dat[i], 16'h0180);
    chk("single_rise", rise_cyc - last_stb_cyc, 4);
    chk("single_vld_low", stim_bus.cur_valid, 0);
    chk("single_hold", stim_bus.cur_data, 16'h0180);

    // Backpressure: stable for 10 cycles, one handshake on release
    stim_bus.cur_ready = 1'b0;
    hs_dat.delete();
    send_frame(8'hA0, 16'h1234);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!stim_bus.cur_valid || stim_bus.cur_data != 16'h1234) bad++;
    end
    chk("bp_stable", bad, 0);
    stim_bus.cur_ready = 1'b1;
    tick(5);
    chk("bp_cnt", hs_dat.size(), 1);
    if (hs_dat.size() > 0) chk("bp_dat", hs_dat[0], 16'h1234);
    chk("bp_vld_low", stim_bus.cur_valid, 0);

    // Overflow: 1 in output stage, 4 queued, 6th dropped
    stim_bus.cur_ready = 1'b0;
    hs_dat.delete();
    for (int i = 1; i <= 6; i++) send_frame(8'hA0, 16'h1000 + 16'(i));
    tick(3);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_vld", stim_bus.cur_valid, 1);
    chk("ovf_head", stim_bus.cur_data, 16'h1001);
    stim_bus.cur_ready = 1'b1;
    tick(12);
    chk("ovf_cnt", hs_dat.size(), 5);
    for (int i = 0; i < hs_dat.size(); i++) chk("ovf_order", hs_dat[i], 16'h1001 + 16'(i));
    chk("ovf_drained", fifo_level, 0);
    chk("ovf_sticky", overflow, 1);

    // Errors: bad header, then timeout, then a clean frame
    hs_dat.delete();
    send_byte(8'h5F);
    tick(3);
    chk("err_hdr", err_cnt, 1);
    chk("err_hdr_noout", hs_dat.size(), 0);
    send_byte(8'hA1);
    send_byte(8'h00);
    tick(TIMEOUT - 50);
    chk("err_tmo_early", err_cnt, 1);
    tick(100);
    chk("err_tmo", err_cnt, 2);
    chk("err_tmo_noout", hs_dat.size(), 0);
    send_frame(8'hA0, 16'h55AA);
    tick(5);
    chk("err_recover_cnt", hs_dat.size(), 1);
    if (hs_dat.size() > 0) chk("err_recover_dat", hs_dat[0], 16'h55AA);

    // Reset while in WAIT_LO with two entries queued
    stim_bus.cur_ready = 1'b0;
    hs_dat.delete();
    send_frame(8'hA0, 16'h2001);
    send_frame(8'hA0, 16'h2002);
    send_frame(8'hA0, 16'h2003);
    send_byte(8'hA0);
    send_byte(8'h20);
    chk("mid_level", fifo_level, 2);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_vld", stim_bus.cur_valid, 0);
    chk("mid_rst_data", stim_bus.cur_data, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_err", err_cnt, 0);
    rst_n = 1'b1;
    stim_bus.cur_ready = 1'b1;
    tick(1);
    send_frame(8'hA1, 16'h3C3D);
    tick(5);
    chk("mid_after_cnt", hs_dat.size(), 2);
    for (int i = 0; i < hs_dat.size(); i++) chk("mid_after_dat", hs_dat[i], 16'h3C3D);

    // Back-to-back entries stream on consecutive cycles
    stim_bus.cur_ready = 1'b0;
    send_frame(8'hA0, 16'h0001);
    send_frame(8'hA1, 16'h0002);
    tick(2);
    hs_dat.delete();
    hs_cyc.delete();
    stim_bus.cur_ready = 1'b1;
    tick(6);
    chk("b2b_cnt", hs_dat.size(), 3);
    if (hs_dat.size() == 3) begin
      chk("b2b_dat0", hs_dat[0], 16'h0001);
      chk("b2b_dat1", hs_dat[1], 16'h0002);
      chk("b2b_dat2", hs_dat[2], 16'h0002);
      chk("b2b_gap0", hs_cyc[1] - hs_cyc[0], 1);
      chk("b2b_gap1", hs_cyc[2] - hs_cyc[1], 1);
    end

    // err_cnt saturation
    repeat (256) send_byte(8'h5F);
    tick(3);
    chk("err_sat", err_cnt, 255);
    chk("err_sat_noout", stim_bus.cur_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
